// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch program counter slice:
// next-PC select encodings, the PC unit state machine states and the
// default vector constants used when a parent does not override them.
package ifetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
    localparam int          DEFAULT_INCR         = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC candidate selection and misaligned register-jump
// detection. Holds no state; the PC register lives in the parent.
module next_pc_calc
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INCR  = DEFAULT_INCR
) (
    input  logic [WIDTH-1:0]        pc,
    input  logic [1:0]              pc_src,
    input  logic signed [WIDTH-1:0] branch_offset,
    input  logic [25:0]             jump_target,
    input  logic [WIDTH-1:0]        reg_target,
    output logic [WIDTH-1:0]        pc_plus4,
    output logic [WIDTH-1:0]        next_pc,
    output logic                    misalign
);

    logic signed [WIDTH-1:0] offset_bytes;
    logic [WIDTH-1:0]        branch_tgt;
    logic [WIDTH-1:0]        jump_tgt;
    logic [27:0]             jump_field;
    pc_src_e                 src;

    assign src          = pc_src_e'(pc_src);
    assign pc_plus4     = pc + WIDTH'(INCR);
    assign offset_bytes = branch_offset <<< 2;
    assign branch_tgt   = pc_plus4 + $unsigned(offset_bytes);
    assign jump_field   = {jump_target, 2'b00};

    // Jump keeps the PC+4 region bits above the 28-bit field; narrow PCs
    // simply keep the low part of the field.
    if (WIDTH > 28) begin : g_wide_jump
        assign jump_tgt = {pc_plus4[WIDTH-1:28], jump_field};
    end else begin : g_narrow_jump
        assign jump_tgt = jump_field[WIDTH-1:0];
    end

    // Only register jumps can produce an unaligned target.
    assign misalign = (src == PC_REG) && (reg_target[1:0] != 2'b00);

    // Select the candidate for the requested redirect kind.
    always_comb begin
        next_pc = pc_plus4;
        case (src)
            PC_SEQ:    next_pc = pc_plus4;
            PC_BRANCH: next_pc = branch_tgt;
            PC_JUMP:   next_pc = jump_tgt;
            PC_REG:    next_pc = reg_target;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch program counter with exception entry/return, EPC capture, stall
// and a one-cycle fault state for misaligned register jumps.
module program_counter_unit
    import ifetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               INCR         = DEFAULT_INCR
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic [25:0]      JumpTarget,
    input  logic [WIDTH-1:0] RegTarget,
    input  logic             ExcReq,
    input  logic             Eret,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] EPC,
    output logic             MisalignFault,
    output logic             Valid
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] next_pc;
    logic             misalign;
    logic             fault_q;
    logic             valid_q;
    pc_state_e        state;

    next_pc_calc #(
        .WIDTH (WIDTH),
        .INCR  (INCR)
    ) u_calc (
        .pc            (pc),
        .pc_src        (PCSrc),
        .branch_offset ($signed(BranchOffset)),
        .jump_target   (JumpTarget),
        .reg_target    (RegTarget),
        .pc_plus4      (PCPlus4),
        .next_pc       (next_pc),
        .misalign      (misalign)
    );

    // PC/EPC update and fault FSM; a fault always completes in one cycle
    // regardless of stall or exception inputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc      <= RESET_VECTOR;
            epc     <= '0;
            state   <= ST_RUN;
            fault_q <= 1'b0;
            valid_q <= 1'b1;
        end else begin
            case (state)
                ST_FAULT: begin
                    pc      <= EXC_VECTOR;
                    state   <= ST_RUN;
                    fault_q <= 1'b0;
                    valid_q <= 1'b1;
                end
                default: begin
                    fault_q <= 1'b0;
                    valid_q <= 1'b1;
                    if (ExcReq) begin
                        epc <= pc;
                        pc  <= EXC_VECTOR;
                    end else if (Eret) begin
                        pc <= epc;
                    end else if (!Stall) begin
                        if (misalign) begin
                            epc     <= pc;
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
            endcase
        end
    end

    assign PCResult      = pc;
    assign EPC           = epc;
    assign MisalignFault = fault_q;
    assign Valid         = valid_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: a 32-bit and a 16-bit instance
// share stimulus; a reference model predicts each edge's outputs, the
// driver queues them and a separate monitor pops and compares.
module tb_program_counter_unit;

    localparam longint RV   = 64'h0;
    localparam longint EV   = 64'h80;
    localparam int     NRND = 300;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        ExcReq = 1'b0;
    logic        Eret = 1'b0;
    logic [1:0]  PCSrc = 2'd0;
    logic [31:0] BranchOffset = '0;
    logic [25:0] JumpTarget = '0;
    logic [31:0] RegTarget = '0;

    logic [31:0] pc32, p4_32, epc32;
    logic        mf32, v32;
    logic [15:0] pc16, p4_16, epc16;
    logic        mf16, v16;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    typedef struct {
        int               due;
        logic [1:0][31:0] pc;
        logic [1:0][31:0] p4;
        logic [1:0][31:0] epc;
        logic [1:0]       mf;
        logic [1:0]       v;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, one lane per instance width.
    longint m_pc[2];
    longint m_epc[2];
    bit     m_flt[2];
    int     wd[2] = '{32, 16};

    program_counter_unit #(.WIDTH(32)) u32 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
        .BranchOffset(BranchOffset), .JumpTarget(JumpTarget),
        .RegTarget(RegTarget), .ExcReq(ExcReq), .Eret(Eret),
        .PCResult(pc32), .PCPlus4(p4_32), .EPC(epc32),
        .MisalignFault(mf32), .Valid(v32)
    );

    program_counter_unit #(
        .WIDTH(16), .RESET_VECTOR(16'h0000), .EXC_VECTOR(16'h0080), .INCR(4)
    ) u16 (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .PCSrc(PCSrc),
        .BranchOffset(BranchOffset[15:0]), .JumpTarget(JumpTarget),
        .RegTarget(RegTarget[15:0]), .ExcReq(ExcReq), .Eret(Eret),
        .PCResult(pc16), .PCPlus4(p4_16), .EPC(epc16),
        .MisalignFault(mf16), .Valid(v16)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one edge of the architectural rules to both model lanes and
    // return the outputs visible after that edge.
    function automatic exp_t model_step(input bit rst, input bit st, input bit [1:0] src,
                                        input logic [31:0] off, input logic [25:0] jt,
                                        input logic [31:0] rt, input bit exc, input bit er);
        exp_t   e;
        longint mask, p4, t, soff;
        soff = longint'($signed(off));
        for (int l = 0; l < 2; l++) begin
            mask = (64'd1 << wd[l]) - 1;
            if (rst) begin
                m_pc[l] = RV & mask; m_epc[l] = 0; m_flt[l] = 0;
            end else if (m_flt[l]) begin
                m_pc[l] = EV & mask; m_flt[l] = 0;
            end else if (exc) begin
                m_epc[l] = m_pc[l]; m_pc[l] = EV & mask;
            end else if (er) begin
                m_pc[l] = m_epc[l];
            end else if (!st) begin
                p4 = (m_pc[l] + 4) & mask;
                case (src)
                    2'd0:    t = p4;
                    2'd1:    t = (p4 + soff * 4) & mask;
                    2'd2:    t = (((p4 >> 28) << 28) + longint'(jt) * 4) & mask;
                    default: t = longint'(rt) & mask;
                endcase
                if (src == 2'd3 && (rt % 4) != 0) begin
                    m_epc[l] = m_pc[l]; m_flt[l] = 1;
                end else begin
                    m_pc[l] = t;
                end
            end
            e.pc[l]  = 32'(m_pc[l]);
            e.p4[l]  = 32'((m_pc[l] + 4) & mask);
            e.epc[l] = 32'(m_epc[l]);
            e.mf[l]  = m_flt[l];
            e.v[l]   = !m_flt[l];
        end
        return e;
    endfunction

    // Drive one cycle's inputs, queue the prediction, then advance past the edge.
    task automatic issue(input bit rst, input bit st, input bit [1:0] src,
                         input logic [31:0] off, input logic [25:0] jt,
                         input logic [31:0] rt, input bit exc, input bit er);
        exp_t e;
        Stall = st; PCSrc = src; BranchOffset = off; JumpTarget = jt;
        RegTarget = rt; ExcReq = exc; Eret = er;
        if (rst && !Reset) begin
            @(negedge Clk); #1;
            Reset = 1'b1;
            #1 chk("async_reset_pc", pc32, 32'h0);
        end
        Reset = rst;
        e = model_step(rst, st, src, off, jt, rt, exc, er);
        e.due = edge_cnt + 1;
        exp_q.push_back(e);
        @(posedge Clk); #1;
    endtask

    task automatic load(input logic [31:0] a);
        issue(0, 0, 2'd3, 32'h0, 26'h0, a, 0, 0);
    endtask

    task automatic seq();
        issue(0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0);
    endtask

    // Monitor: compare every queued prediction once its edge has occurred.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                e = exp_q.pop_front();
                if (e.due < edge_cnt) begin
                    n_checks++; n_fail++;
                    $display("FAIL stale_expectation: due %0d, now %0d", e.due, edge_cnt);
                end else begin
                    chk("sb_pc32",   pc32,               e.pc[0]);
                    chk("sb_p4_32",  p4_32,              e.p4[0]);
                    chk("sb_epc32",  epc32,              e.epc[0]);
                    chk("sb_mf32",   {31'h0, mf32},      {31'h0, e.mf[0]});
                    chk("sb_v32",    {31'h0, v32},       {31'h0, e.v[0]});
                    chk("sb_pc16",   {16'h0, pc16},      e.pc[1]);
                    chk("sb_p4_16",  {16'h0, p4_16},     e.p4[1]);
                    chk("sb_epc16",  {16'h0, epc16},     e.epc[1]);
                    chk("sb_mf16",   {31'h0, mf16},      {31'h0, e.mf[1]});
                    chk("sb_v16",    {31'h0, v16},       {31'h0, e.v[1]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by constrained-random traffic.
    initial begin
        logic [31:0] rt, off;
        #2 Reset = 1'b1;
        #1 chk("reset_pc", pc32, 32'h0);
        chk("reset_epc", epc32, 32'h0);
        chk("reset_valid", {31'h0, v32}, 32'h1);
        chk("reset_fault", {31'h0, mf32}, 32'h0);
        issue(1, 0, 2'd0, 0, 0, 0, 0, 0);
        seq(); seq();

        // Reset asserted between edges, then three sequential edges.
        #5 Reset = 1'b1;
        #1 chk("midcycle_reset_pc", pc32, 32'h0);
        issue(1, 0, 2'd0, 0, 0, 0, 0, 0);
        seq(); chk("seq_4", pc32, 32'h4);
        seq(); chk("seq_8", pc32, 32'h8);
        seq(); chk("seq_c", pc32, 32'hC);

        // Backward branch, then stall holds.
        load(32'h10);
        issue(0, 0, 2'd1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        chk("branch_back", pc32, 32'hC);
        issue(0, 1, 2'd0, 0, 0, 0, 0, 0);
        issue(0, 1, 2'd2, 0, 26'h3FF, 0, 0, 0);
        chk("stall_hold", pc32, 32'hC);

        // Jump keeps the upper region bits.
        load(32'h1000_0040);
        issue(0, 0, 2'd2, 0, 26'h10, 0, 0, 0);
        chk("jump", pc32, 32'h1000_0040);
        chk("jump16", {16'h0, pc16}, 32'h40);

        // Misaligned register jump; exception/stall during FAULT are ignored.
        load(32'h20);
        issue(0, 0, 2'd3, 0, 0, 32'h103, 0, 0);
        chk("fault_mf", {31'h0, mf32}, 32'h1);
        chk("fault_valid", {31'h0, v32}, 32'h0);
        chk("fault_epc", epc32, 32'h20);
        issue(0, 1, 2'd0, 0, 0, 0, 1, 1);
        chk("fault_exit_pc", pc32, 32'h80);
        chk("fault_exit_valid", {31'h0, v32}, 32'h1);
        chk("fault_exit_epc", epc32, 32'h20);

        // Exception overrides stall, then return.
        load(32'h44);
        issue(0, 1, 2'd1, 32'h5, 0, 0, 1, 0);
        chk("exc_pc", pc32, 32'h80);
        chk("exc_epc", epc32, 32'h44);
        issue(0, 1, 2'd0, 0, 0, 0, 0, 1);
        chk("eret_pc", pc32, 32'h44);

        // Wrap and simultaneous ExcReq/Eret.
        load(32'hFFFF_FFFC);
        seq();
        chk("wrap16", {16'h0, pc16}, 32'h0);
        chk("wrap32", pc32, 32'h0);
        load(32'h8);
        issue(0, 0, 2'd0, 0, 0, 0, 1, 1);
        chk("exc_eret_epc16", {16'h0, epc16}, 32'h8);
        chk("exc_eret_pc16", {16'h0, pc16}, 32'h80);

        // Reset during the FAULT cycle.
        load(32'h20);
        issue(0, 0, 2'd3, 0, 0, 32'h102, 0, 0);
        #5 Reset = 1'b1;
        #1 chk("fault_reset_mf", {31'h0, mf32}, 32'h0);
        chk("fault_reset_valid", {31'h0, v32}, 32'h1);
        chk("fault_reset_pc", pc32, 32'h0);
        issue(1, 0, 2'd0, 0, 0, 0, 0, 0);
        seq();

        // Random traffic against the model.
        for (int i = 0; i < NRND; i++) begin
            rt = $urandom;
            if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
            off = 32'($signed($urandom_range(64)) - 32);
            issue($urandom_range(59) == 0, $urandom_range(4) == 0, 2'($urandom_range(3)),
                  off, 26'($urandom), rt, $urandom_range(11) == 0, $urandom_range(9) == 0);
        end
        issue(0, 0, 2'd0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Parametrised successor to the single-cycle ProgramCounter for the MIPS datapath. It holds the fetch PC and computes the next PC internally from a select code: sequential, branch, jump, register jump, exception entry or exception return. It also supports stall, captures the exception PC (EPC), and detects misaligned redirect targets. It sits at the head of the IF stage and drives instruction-memory address and the PC+4 value passed to IF/ID.

Parameters:
WIDTH, 32, PC/address width in bits (>= 8).
RESET_VECTOR, 32'h00000000, PC value loaded on Reset.
EXC_VECTOR, 32'h00000080, PC loaded on exception entry or misalignment fault.
INCR, 4, sequential increment in bytes.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high reset.
Stall  input  1  hold PC (hazard unit); 1 = no sequential/branch/jump update.
PCSrc  input  2  next-PC select: 0 = seq, 1 = branch, 2 = jump, 3 = register jump.
BranchOffset  input  WIDTH  sign-extended word offset, before the <<2.
JumpTarget  input  26  instruction target field.
RegTarget  input  WIDTH  rs value for JR.
ExcReq  input  1  exception request; takes effect next edge.
Eret  input  1  return from exception.
PCResult  output  WIDTH  current PC.
PCPlus4  output  WIDTH  PCResult + INCR, combinational.
EPC  output  WIDTH  saved exception PC.
MisalignFault  output  1  one-cycle pulse; redirect target had bits [1:0] != 0.
Valid  output  1  PCResult is a fetchable address (low for one cycle after a fault).

Behaviour:
- Reset asserted, at any time, including mid-fault: PCResult = RESET_VECTOR, EPC = 0, MisalignFault = 0, Valid = 1, state = RUN. This is the only asynchronous path; everything else updates on the rising Clk edge.
- Candidate next PC, all arithmetic modulo 2^WIDTH with no overflow flag:
  - seq = PC + INCR
  - branch = PC + INCR + (BranchOffset << 2)
  - jump = {PCPlus4[WIDTH-1:28], JumpTarget, 2'b00}
  - reg = RegTarget
- Update priority per edge, highest first:
  1. ExcReq: EPC <= PCResult; PC <= EXC_VECTOR. Overrides Stall and PCSrc.
  2. Eret: PC <= EPC. Overrides Stall.
  3. Stall: PC holds; misalignment is not checked.
  4. PCSrc: PC <= candidate.
- Misalignment check applies only to PCSrc = 3 (reg). Branch and jump targets are aligned by construction. If RegTarget[1:0] != 0 and not stalled:
  - PC is not loaded with RegTarget.
  - EPC <= PCResult; MisalignFault = 1 for exactly that cycle.
  - State -> FAULT.
- FAULT state, one cycle:
  - Valid = 0 and MisalignFault = 1.
  - Next edge: PC <= EXC_VECTOR, Valid = 1, state -> RUN.
  - ExcReq and Eret during FAULT are ignored; Stall is ignored (the fault completes regardless).
- Eret and ExcReq in the same cycle: ExcReq wins and EPC is overwritten.
- Wrap: PC = 2^WIDTH - INCR with seq gives 0.
- Latency: select inputs to PCResult is 1 edge; fault to EXC_VECTOR is 2 edges.

Decomposition:
- Shared package ifetch_pkg holds:
  - PCSrc encodings: PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG.
  - State enum: ST_RUN, ST_FAULT.
  - Default vector constants.
- One natural sub-module, next_pc_calc: combinational candidate and misalign-flag computation. The top level holds the PC/EPC registers and the FSM.

Test Plan:
1. Reset asserted mid-cycle, then released; 3 edges with PCSrc = 0 -> PCResult 0x0 immediately on assertion, then 0x4, 0x8, 0xC.
2. PC = 0x10, PCSrc = 1, BranchOffset = 0xFFFFFFFE -> PCResult 0xC; then Stall = 1 for 2 edges -> stays 0xC.
3. PC = 0x10000040, PCSrc = 2, JumpTarget = 0x0000010 -> PCResult 0x10000040.
4. PC = 0x20, PCSrc = 3, RegTarget = 0x103 -> MisalignFault = 1, Valid = 0, EPC = 0x20; next edge PCResult = 0x80, Valid = 1.
5. PC = 0x44, ExcReq = 1 with Stall = 1 -> PCResult 0x80, EPC 0x44; then Eret = 1 -> PCResult 0x44.
6. WIDTH = 16, PC = 0xFFFC, seq -> 0x0000; ExcReq and Eret together at PC 0x8 -> EPC 0x8, PC 0x80.
